// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Define MULT_SIGNED_EN for two's-complement operation; the default build is unsigned.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      HOLD    = 2'd2
   } mult_state_t;

`ifdef MULT_SIGNED_EN
   localparam bit SIGNED_MODE = 1'b1;
`else
   localparam bit SIGNED_MODE = 1'b0;
`endif

   // Iteration counter only ever needs to reach WIDTH-1.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/Done handshake and result bus of seq_multiplier.
// Start is a level request; Done stays high until Start is released, and S must hold while Busy.
interface seq_multiplier_if #(
   parameter int WIDTH = 8
);
   logic             Start;
   logic             ClearA_LoadB;
   logic [WIDTH-1:0] S;
   logic             Xval;
   logic [WIDTH-1:0] Aval;
   logic [WIDTH-1:0] Bval;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, ClearA_LoadB, S,
      input  Xval, Aval, Bval, Busy, Done
   );

   modport slave (
      input  Start, ClearA_LoadB, S,
      output Xval, Aval, Bval, Busy, Done
   );
endinterface

// File: rtl/seq_multiplier_step.sv
// One combinational iteration: conditional add (or final subtract in signed mode) into X:A,
// then a one-bit right shift of X:A:B.
module mult_step
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             X,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] S,
   input  logic             last,
   output logic             new_X,
   output logic [WIDTH-1:0] new_A,
   output logic [WIDTH-1:0] new_B
);

   logic [WIDTH:0] ext_s;
   logic [WIDTH:0] sum;
   logic           fill;

   always_comb begin
      ext_s = {SIGNED_MODE & S[WIDTH-1], S};
      // X mirrors A's MSB in signed mode, so {X,A} is already the sign-extended A.
      if (!B[0])
         sum = {X, A};
      else if (SIGNED_MODE && last)
         sum = {X, A} - ext_s;
      else
         sum = {X, A} + ext_s;
      fill  = SIGNED_MODE & sum[WIDTH];
      new_X = fill;
      new_A = sum[WIDTH:1];
      new_B = {sum[0], B[WIDTH-1:1]};
   end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH x WIDTH multiplier: IDLE/COMPUTE/HOLD control around an X:A:B register.
// Signedness is chosen at build time with MULT_SIGNED_EN.
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   seq_multiplier_if.slave      bus,
   output mult_state_t          dbg_state_o
);

   localparam int CNT_W = cnt_width(WIDTH);

   mult_state_t      state_q, state_d;
   logic             x_q, x_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last;
   logic             step_x;
   logic [WIDTH-1:0] step_a;
   logic [WIDTH-1:0] step_b;
   logic             busy, done;

   assign last = (cnt_q == CNT_W'(WIDTH - 1));

   mult_step #(.WIDTH(WIDTH)) u_step (
      .X     (x_q),
      .A     (a_q),
      .B     (b_q),
      .S     (bus.S),
      .last  (last),
      .new_X (step_x),
      .new_A (step_a),
      .new_B (step_b)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         x_q     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            // A load takes priority over a simultaneous Start.
            if (bus.ClearA_LoadB) begin
               x_d = 1'b0;
               a_d = '0;
               b_d = bus.S;
            end else if (bus.Start) begin
               x_d     = 1'b0;
               a_d     = '0;
               cnt_d   = '0;
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            x_d   = step_x;
            a_d   = step_a;
            b_d   = step_b;
            cnt_d = last ? '0 : cnt_q + 1'b1;
            if (last) state_d = HOLD;
         end
         HOLD: begin
            if (!bus.Start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == COMPUTE);
      done = (state_q == HOLD);
   end

   assign bus.Xval    = x_q;
   assign bus.Aval    = a_q;
   assign bus.Bval    = b_q;
   assign bus.Busy    = busy;
   assign bus.Done    = done;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed multiplies with literal products, a cycle-level model
// compared every clock, handshake corner cases and an asynchronous reset mid-compute.
module tb_seq_multiplier;
   import mult_pkg::*;

   localparam int W = 8;

   logic        Clk;
   logic        Reset_n;
   mult_state_t dbg_state;
   int          errors;
   int          checks;
   bit          cmp_en;

   seq_multiplier_if #(.WIDTH(W)) bus ();

   seq_multiplier #(.WIDTH(W)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: product by plain arithmetic, W-cycle latency, level handshake.
   int               m_left;
   bit               m_done;
   logic             m_x;
   logic [W-1:0]     m_a, m_b, m_opb, m_ops;

   function automatic logic [2*W-1:0] product(input logic [W-1:0] b, input logic [W-1:0] s);
      logic signed [2*W-1:0] bs, ss;
      if (SIGNED_MODE) begin
         bs = $signed(b);
         ss = $signed(s);
         return bs * ss;
      end
      return {{W{1'b0}}, b} * {{W{1'b0}}, s};
   endfunction

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m_left = 0; m_done = 0; m_x = 0; m_a = '0; m_b = '0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1;
            {m_a, m_b} = product(m_opb, m_ops);
            // Signed mode: X is the product sign; unsigned mode: X ends at zero.
            m_x = SIGNED_MODE ? m_a[W-1] : 1'b0;
         end
      end else if (m_done) begin
         if (!bus.Start) m_done = 0;
      end else if (bus.ClearA_LoadB) begin
         m_x = 0; m_a = '0; m_b = bus.S;
      end else if (bus.Start) begin
         m_left = W; m_opb = m_b; m_ops = bus.S; m_x = 0; m_a = '0;
      end
   end

   always @(negedge Clk) begin
      if (cmp_en && Reset_n) begin
         check("busy_vs_model", 64'(bus.Busy), 64'(m_left > 0));
         check("done_vs_model", 64'(bus.Done), 64'(m_done));
         if (m_left == 0) begin
            check("x_vs_model", 64'(bus.Xval), 64'(m_x));
            check("ab_vs_model", 64'({bus.Aval, bus.Bval}), 64'({m_a, m_b}));
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      bus.Start = 1'b0;
      bus.ClearA_LoadB = 1'b0;
      bus.S = '0;
      repeat (2) tick();
      Reset_n = 1'b1;
      tick();
   endtask

   // Loads B, starts with S and waits for Done; leaves Start high.
   task automatic run_mul(input logic [W-1:0] b, input logic [W-1:0] s,
                          input logic [2*W-1:0] exp_ab, input logic exp_x);
      int  busy_cnt;
      bit  got;
      bus.ClearA_LoadB = 1'b1;
      bus.S = b;
      tick();
      bus.ClearA_LoadB = 1'b0;
      bus.S = s;
      bus.Start = 1'b1;
      busy_cnt = 0;
      got = 0;
      for (int i = 0; i < 3 * W; i++) begin
         @(negedge Clk);
         if (bus.Done) begin
            got = 1;
            break;
         end
         if (bus.Busy) busy_cnt++;
      end
      check("done_seen", 64'(got), 64'd1);
      check("busy_cycles", 64'(busy_cnt), 64'(W));
      check("product_literal", 64'({bus.Aval, bus.Bval}), 64'(exp_ab));
      check("x_literal", 64'(bus.Xval), 64'(exp_x));
   endtask

   task automatic release_start();
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      check("done_fell", 64'(bus.Done), 64'd0);
      check("idle_state", 64'(dbg_state), 64'(IDLE));
   endtask

   initial begin
      int hold_busy;
      errors = 0;
      checks = 0;
      cmp_en = 0;
      do_reset();
      check("reset_ab", 64'({bus.Aval, bus.Bval}), 64'd0);
      check("reset_x", 64'(bus.Xval), 64'd0);
      check("reset_busy_done", 64'({bus.Busy, bus.Done}), 64'd0);
      check("reset_state", 64'(dbg_state), 64'(IDLE));
      cmp_en = 1;

`ifdef MULT_SIGNED_EN
      run_mul(8'h07, 8'hC5, 16'hFE63, 1'b1); release_start();
      run_mul(8'h80, 8'h80, 16'h4000, 1'b0); release_start();
      run_mul(8'hFF, 8'hFF, 16'h0001, 1'b0); release_start();
      run_mul(8'h00, 8'h9A, 16'h0000, 1'b0); release_start();
      run_mul(8'h7F, 8'h80, 16'hC080, 1'b1);
`else
      run_mul(8'h3B, 8'h07, 16'h019D, 1'b0); release_start();
      run_mul(8'hFF, 8'hFF, 16'hFE01, 1'b0); release_start();
      run_mul(8'h00, 8'hA5, 16'h0000, 1'b0); release_start();
      run_mul(8'h80, 8'h02, 16'h0100, 1'b0); release_start();
      run_mul(8'hC8, 8'h81, 16'h64C8, 1'b0);
`endif

      // Start held high: the block must sit in HOLD and never re-run.
      hold_busy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         if (bus.Busy) hold_busy++;
         check("hold_done_high", 64'(bus.Done), 64'd1);
      end
      check("hold_no_rerun", 64'(hold_busy), 64'd0);
      release_start();

      // Load and Start together: load only.
      bus.ClearA_LoadB = 1'b1;
      bus.Start = 1'b1;
      bus.S = 8'h5A;
      tick();
      bus.ClearA_LoadB = 1'b0;
      bus.Start = 1'b0;
      @(negedge Clk);
      check("load_start_busy", 64'(bus.Busy), 64'd0);
      check("load_start_b", 64'(bus.Bval), 64'h5A);
      check("load_start_a", 64'(bus.Aval), 64'd0);

      // Asynchronous reset four cycles into a compute.
      bus.ClearA_LoadB = 1'b1;
      bus.S = 8'hE7;
      tick();
      bus.ClearA_LoadB = 1'b0;
      bus.S = 8'h3C;
      bus.Start = 1'b1;
      repeat (5) @(negedge Clk);
      check("busy_before_reset", 64'(bus.Busy), 64'd1);
      #2;
      Reset_n = 1'b0;
      #1;
      check("async_reset_outs", 64'({bus.Xval, bus.Aval, bus.Bval, bus.Busy, bus.Done}), 64'd0);
      check("async_reset_state", 64'(dbg_state), 64'(IDLE));
      bus.Start = 1'b0;
      tick();
      Reset_n = 1'b1;
      tick();
`ifdef MULT_SIGNED_EN
      run_mul(8'hFD, 8'h05, 16'hFFF1, 1'b1);
`else
      run_mul(8'hE7, 8'h3C, 16'h3624, 1'b0);
`endif
      release_start();

      cmp_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
